// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, condition-code bit positions,
// the default condition-code reset value and the response-register states.
package alu_pkg;

  localparam logic [3:0] ALUFUN_ADD = 4'd0;
  localparam logic [3:0] ALUFUN_SUB = 4'd1;
  localparam logic [3:0] ALUFUN_AND = 4'd2;
  localparam logic [3:0] ALUFUN_XOR = 4'd3;

  // Bit positions inside the {ZF, SF, OF} condition-code vector.
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // ZF=1, SF=0, OF=0 out of reset.
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  // Codes 4..15 are accepted but produce no result and never touch cc.
  function automatic logic fun_legal(input logic [3:0] fun);
    return (fun <= ALUFUN_XOR);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add / sub (a - b) / and / xor with {ZF, SF, OF}.
// Unknown function codes give a zero result and zero flags.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  fun_i,
  output logic [31:0] vale_o,
  output logic [2:0]  cc_o
);

  logic of;

  // Result and signed overflow per function code.
  always_comb begin
    vale_o = '0;
    of     = 1'b0;
    case (fun_i)
      ALUFUN_ADD: begin
        vale_o = a_i + b_i;
        of     = (a_i[31] == b_i[31]) && (vale_o[31] != a_i[31]);
      end
      ALUFUN_SUB: begin
        vale_o = a_i - b_i;
        of     = (a_i[31] != b_i[31]) && (vale_o[31] != a_i[31]);
      end
      ALUFUN_AND: vale_o = a_i & b_i;
      ALUFUN_XOR: vale_o = a_i ^ b_i;
      default: begin
        vale_o = '0;
        of     = 1'b0;
      end
    endcase
  end

  // Flag packing; flags are forced low for unknown codes.
  always_comb begin
    cc_o = '0;
    if (fun_legal(fun_i)) begin
      cc_o[CC_ZF] = (vale_o == 32'd0);
      cc_o[CC_SF] = vale_o[31];
      cc_o[CC_OF] = of;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin sequencer sharing one ALU between the execute stage (req0) and
// the address/aux unit (req1). One-entry registered result with requester tag;
// owns the architectural {ZF, SF, OF} register, which only req0 may write.
// Optional: define ALU_SCHED_PERF_EN for saturating per-requester grant counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RSP_EMPTY | result register free, rsp_valid=0
// RSP_FULL  | result register holds a response, rsp_valid=1
module alu_sched #(
  parameter logic [2:0] CC_RESET = alu_pkg::CC_RESET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_fun,
  input  logic        req0_setcc,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_fun,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_vale,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic [2:0]  cc,
  output logic [15:0] perf_cnt0,
  output logic [15:0] perf_cnt1
);

  import alu_pkg::*;

  rsp_state_e  state_q, state_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_vale_q, rsp_vale_d;
  logic        rsp_err_q, rsp_err_d;
  logic [2:0]  cc_q, cc_d;
  logic        lg_q, lg_d;

  logic        can_accept;
  logic        grant0, grant1;
  logic        accept;
  logic        acc_id;
  logic [31:0] alu_a, alu_b, alu_vale;
  logic [3:0]  alu_fun;
  logic [2:0]  alu_cc;
  logic        fun_ok;

  // Round-robin arbitration: a lone requester wins, a tie goes to !lg.
  always_comb begin
    can_accept = (state_q == RSP_EMPTY) | rsp_ready;
    grant0     = req0_valid & (~req1_valid | lg_q);
    grant1     = req1_valid & (~req0_valid | ~lg_q);
    req0_ready = grant0 & can_accept & ~rst;
    req1_ready = grant1 & can_accept & ~rst;
    accept     = req0_ready | req1_ready;
    acc_id     = req1_ready;
  end

  // Operand mux driven by the grant, so the ALU always sees the winner.
  always_comb begin
    alu_a   = grant1 ? req1_a   : req0_a;
    alu_b   = grant1 ? req1_b   : req0_b;
    alu_fun = grant1 ? req1_fun : req0_fun;
    fun_ok  = fun_legal(alu_fun);
  end

  alu u_alu (
    .a_i    (alu_a),
    .b_i    (alu_b),
    .fun_i  (alu_fun),
    .vale_o (alu_vale),
    .cc_o   (alu_cc)
  );

  // Next-state of the result register, cc and last-grant pointer.
  always_comb begin
    state_d    = state_q;
    rsp_id_d   = rsp_id_q;
    rsp_vale_d = rsp_vale_q;
    rsp_err_d  = rsp_err_q;
    cc_d       = cc_q;
    lg_d       = lg_q;

    case (state_q)
      RSP_EMPTY: begin
        if (accept) state_d = RSP_FULL;
      end
      RSP_FULL: begin
        // Drain with a simultaneous accept reloads and stays full.
        if (!accept && rsp_ready) state_d = RSP_EMPTY;
      end
      default: state_d = RSP_EMPTY;
    endcase

    if (accept) begin
      rsp_id_d   = acc_id;
      rsp_vale_d = fun_ok ? alu_vale : 32'd0;
      rsp_err_d  = ~fun_ok;
      lg_d       = acc_id;
      if (req0_ready && req0_setcc && fun_ok) cc_d = alu_cc;
    end
  end

  // Synchronous reset wins over any accept or drain in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RSP_EMPTY;
      rsp_id_q   <= 1'b0;
      rsp_vale_q <= 32'd0;
      rsp_err_q  <= 1'b0;
      cc_q       <= CC_RESET;
      lg_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      rsp_id_q   <= rsp_id_d;
      rsp_vale_q <= rsp_vale_d;
      rsp_err_q  <= rsp_err_d;
      cc_q       <= cc_d;
      lg_q       <= lg_d;
    end
  end

  assign rsp_valid = (state_q == RSP_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_vale  = rsp_vale_q;
  assign rsp_err   = rsp_err_q;
  assign cc        = cc_q;

`ifdef ALU_SCHED_PERF_EN
  logic [15:0] perf0_q, perf0_d;
  logic [15:0] perf1_q, perf1_d;

  // Saturating accept counters per requester.
  always_comb begin
    perf0_d = perf0_q;
    perf1_d = perf1_q;
    if (req0_ready && (perf0_q != 16'hFFFF)) perf0_d = perf0_q + 16'd1;
    if (req1_ready && (perf1_q != 16'hFFFF)) perf1_d = perf1_q + 16'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf0_q <= 16'd0;
      perf1_q <= 16'd0;
    end else begin
      perf0_q <= perf0_d;
      perf1_q <= perf1_d;
    end
  end

  assign perf_cnt0 = perf0_q;
  assign perf_cnt1 = perf1_q;
`else
  assign perf_cnt0 = 16'd0;
  assign perf_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed scenarios plus a randomized
// stream checked against a transaction-level reference model.
module tb_alu_sched;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_setcc;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_fun;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_fun;
  logic        rsp_valid, rsp_id, rsp_err, rsp_ready;
  logic [31:0] rsp_vale;
  logic [2:0]  cc;
  logic [15:0] perf_cnt0, perf_cnt1;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_valid, m_id, m_err, m_lg;
  logic [31:0] m_vale;
  logic [2:0]  m_cc;
  int          m_cnt0, m_cnt1;

  alu_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_fun(req0_fun), .req0_setcc(req0_setcc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_fun(req1_fun),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_vale(rsp_vale),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready), .cc(cc),
    .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] ref_vale(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] f);
    case (f)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Flags from exact signed arithmetic: OF means the true result does not fit.
  function automatic logic [2:0] ref_cc(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] f);
    longint sa, sb, exact;
    logic [31:0] r;
    bit of;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = ref_vale(a, b, f);
    exact = (f == 4'd0) ? sa + sb : sa - sb;
    of = (f <= 4'd1) && (exact != longint'($signed(r)));
    return {r == 32'd0, r[31], of};
  endfunction

  function automatic bit exp_gnt(input int who);
    if (rst) return 1'b0;
    if (m_valid && !rsp_ready) return 1'b0;
    if (who == 0) return req0_valid && (!req1_valid || m_lg == 1'b1);
    return req1_valid && (!req0_valid || m_lg == 1'b0);
  endfunction

  function automatic int exp_p0();
`ifdef ALU_SCHED_PERF_EN
    return m_cnt0;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_p1();
`ifdef ALU_SCHED_PERF_EN
    return m_cnt1;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_vale = 0; m_err = 0;
    m_cc = 3'b100; m_lg = 1; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // Advance one clock and the model with it; ends on the falling edge.
  task automatic tick();
    bit g0, g1, legal;
    logic [31:0] a, b;
    logic [3:0]  f;
    g0 = exp_gnt(0);
    g1 = exp_gnt(1);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (g0 || g1) begin
      a = g1 ? req1_a : req0_a;
      b = g1 ? req1_b : req0_b;
      f = g1 ? req1_fun : req0_fun;
      legal = (f <= 4'd3);
      m_valid = 1; m_id = g1;
      m_vale = legal ? ref_vale(a, b, f) : 32'd0;
      m_err = !legal;
      if (g0 && req0_setcc && legal) m_cc = ref_cc(a, b, f);
      m_lg = g1;
      if (g0 && m_cnt0 < 65535) m_cnt0++;
      if (g1 && m_cnt1 < 65535) m_cnt1++;
    end else if (rsp_ready && m_valid) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic drive0(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f, input bit s);
    req0_valid = v; req0_a = a; req0_b = b; req0_fun = f; req0_setcc = s;
  endtask

  task automatic drive1(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f);
    req1_valid = v; req1_a = a; req1_b = b; req1_fun = f;
  endtask

  task automatic test_reset();
    rst = 1; rsp_ready = 0;
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0);
    tick(); tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    checks++; if ({rsp_id, rsp_err, rsp_vale} !== 34'd0) begin errors++; $display("FAIL reset_rsp: got id=%b err=%b vale=%h want zeros", rsp_id, rsp_err, rsp_vale); end
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL reset_cc: got %b want 100", cc); end
    checks++; if ({perf_cnt0, perf_cnt1} !== 32'd0) begin errors++; $display("FAIL reset_perf: got %h/%h want 0", perf_cnt0, perf_cnt1); end
    drive0(1, 1, 2, 0, 1); drive1(1, 3, 4, 0); rsp_ready = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
    tick();
    rst = 0;
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0);
  endtask

  task automatic test_tie();
    logic [31:0] a0, b0, a1, b1;
    rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      drive0(1, a0, b0, 4'd0, 0); drive1(1, a1, b1, 4'd0);
      #1;
      checks++; if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_grant%0d: got %b%b", k, req0_ready, req1_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(k % 2)) begin errors++; $display("FAIL tie_rsp%0d: got valid=%b id=%b want 1/%0d", k, rsp_valid, rsp_id, k % 2); end
      checks++; if (rsp_vale !== ((k % 2 == 0) ? a0 + b0 : a1 + b1)) begin errors++; $display("FAIL tie_vale%0d: got %h", k, rsp_vale); end
    end
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0);
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL tie_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_add_cc();
    rsp_ready = 1;
    drive0(1, 32'h7FFED28A, 32'h7FFED28A, 4'd0, 1);
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL add_ready: got %b%b want 10", req0_ready, req1_ready); end
    tick();
    drive0(0, 0, 0, 0, 0);
    checks++; if (rsp_vale !== 32'hFFFDA514 || rsp_id !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp: got vale=%h id=%b v=%b want FFFDA514/0/1", rsp_vale, rsp_id, rsp_valid); end
    checks++; if (cc !== 3'b011) begin errors++; $display("FAIL add_cc: got %b want 011", cc); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, ev;
    logic [2:0]  ecc;
    a = $urandom; b = $urandom;
    ev = a ^ b; ecc = {ev == 0, ev[31], 1'b0};
    rsp_ready = 1;
    drive0(1, a, b, 4'd3, 1); drive1(0, 0, 0, 0);
    tick();
    checks++; if (rsp_vale !== ev || cc !== ecc) begin errors++; $display("FAIL bp_load: got vale=%h cc=%b want %h/%b", rsp_vale, cc, ev, ecc); end
    rsp_ready = 0;
    drive0(1, 32'h5, 32'h6, 4'd0, 1); drive1(1, 32'h100, 32'h23, 4'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d: got %b%b want 00", k, req0_ready, req1_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_vale !== ev || rsp_err !== 1'b0 || cc !== ecc) begin errors++; $display("FAIL bp_hold%0d: got v=%b id=%b vale=%h err=%b cc=%b", k, rsp_valid, rsp_id, rsp_vale, rsp_err, cc); end
    end
    rsp_ready = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got %b%b want 01", req0_ready, req1_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_vale !== 32'h000000DD) begin errors++; $display("FAIL bp_reload: got v=%b id=%b vale=%h want 1/1/000000DD", rsp_valid, rsp_id, rsp_vale); end
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_sub_cc();
    logic [2:0] cc_before;
    cc_before = m_cc;
    rsp_ready = 1;
    drive0(1, 32'h11, 32'h133, 4'd1, 0);
    tick();
    checks++; if (rsp_vale !== 32'hFFFFFEDE || cc !== cc_before) begin errors++; $display("FAIL sub_nocc: got vale=%h cc=%b want FFFFFEDE/%b", rsp_vale, cc, cc_before); end
    drive0(1, 32'h11, 32'h133, 4'd1, 1);
    tick();
    checks++; if (rsp_vale !== 32'hFFFFFEDE || cc !== 3'b010) begin errors++; $display("FAIL sub_cc: got vale=%h cc=%b want FFFFFEDE/010", rsp_vale, cc); end
    drive0(0, 0, 0, 0, 0); drive1(1, 32'h1100, 32'h11, 4'd2);
    tick();
    checks++; if (rsp_vale !== 32'd0 || rsp_id !== 1'b1 || cc !== 3'b010) begin errors++; $display("FAIL and_req1: got vale=%h id=%b cc=%b want 0/1/010", rsp_vale, rsp_id, cc); end
    drive1(0, 0, 0, 0);
  endtask

  task automatic test_illegal();
    rsp_ready = 1;
    drive0(1, $urandom | 32'h1, $urandom, 4'd5, 1);
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_vale !== 32'd0 || rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_rsp: got v=%b vale=%h err=%b want 1/0/1", rsp_valid, rsp_vale, rsp_err); end
    checks++; if (cc !== 3'b010) begin errors++; $display("FAIL illegal_cc: got %b want 010", cc); end
    drive0(1, 32'd1, 32'd2, 4'd0, 0);
    tick();
    checks++; if (rsp_err !== 1'b0 || rsp_vale !== 32'd3) begin errors++; $display("FAIL illegal_next: got err=%b vale=%h want 0/3", rsp_err, rsp_vale); end
    drive0(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 0;
    drive0(1, 32'h80000000, 32'h80000000, 4'd0, 1);
    tick();
    drive1(1, 32'h9, 32'h9, 4'd3);
    rsp_ready = 1; rst = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rstmid_ready: got %b%b want 00", req0_ready, req1_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || cc !== 3'b100) begin errors++; $display("FAIL rstmid_state: got v=%b cc=%b want 0/100", rsp_valid, cc); end
    checks++; if ({perf_cnt0, perf_cnt1} !== 32'd0) begin errors++; $display("FAIL rstmid_perf: got %h/%h want 0", perf_cnt0, perf_cnt1); end
    rst = 0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rstmid_tie: got %b%b want 10", req0_ready, req1_ready); end
    tick();
    checks++; if (rsp_id !== 1'b0 || rsp_vale !== 32'd0 || cc !== 3'b101) begin errors++; $display("FAIL rstmid_first: got id=%b vale=%h cc=%b want 0/0/101", rsp_id, rsp_vale, cc); end
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    bit last0, last1;
    last0 = 0; last1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (!(req0_valid && !last0))
        drive0($urandom_range(0, 3) != 0, $urandom, $urandom,
               ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1);
      if (!(req1_valid && !last1))
        drive1($urandom_range(0, 3) != 0, $urandom, $urandom,
               ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3)));
      rst = ($urandom_range(0, 59) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (req0_ready !== exp_gnt(0) || req1_ready !== exp_gnt(1)) begin errors++; $display("FAIL rnd_ready@%0d: got %b%b want %b%b", i, req0_ready, req1_ready, exp_gnt(0), exp_gnt(1)); end
      last0 = req0_ready; last1 = req1_ready;
      tick();
      checks++; if (rsp_valid !== m_valid || cc !== m_cc) begin errors++; $display("FAIL rnd_state@%0d: got v=%b cc=%b want %b/%b", i, rsp_valid, cc, m_valid, m_cc); end
      if (m_valid) begin
        checks++; if (rsp_id !== m_id || rsp_vale !== m_vale || rsp_err !== m_err) begin errors++; $display("FAIL rnd_rsp@%0d: got id=%b vale=%h err=%b want %b/%h/%b", i, rsp_id, rsp_vale, rsp_err, m_id, m_vale, m_err); end
      end
      checks++; if (int'(perf_cnt0) != exp_p0() || int'(perf_cnt1) != exp_p1()) begin errors++; $display("FAIL rnd_perf@%0d: got %0d/%0d want %0d/%0d", i, perf_cnt0, perf_cnt1, exp_p0(), exp_p1()); end
    end
    rst = 0;
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; rsp_ready = 0;
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_tie();
    test_add_cc();
    test_backpressure();
    test_sub_cc();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
